// File: rtl/beta_cmp_stage.sv
// beta_cmp_stage
//   Execute-stage consumer placed directly after the adder/subtractor. It
//   captures the sum S and the Z/V/N flags, forms the final ALU result
//   (S pass-through or a BETA compare CMPEQ/CMPLT/CMPLE packed as a 0/1
//   word), and holds it with its destination tag in a 2-entry skid buffer
//   toward writeback. A sticky overflow flag tracks ADD/SUB overflow.
//
// Handshake: a transfer happens on a rising CLK edge where valid and ready
//   are both 1 (accept = IN_VALID & IN_READY, pop = OUT_VALID & OUT_READY).
//   IN_READY and OUT_VALID come from registered state only, so neither
//   depends combinationally on IN_VALID or OUT_READY. OUT_RESULT/OUT_RC
//   stay stable while OUT_VALID=1 and OUT_READY=0.
//
// Ports:
//   CLK, RESET      clock (rising edge), asynchronous active-high reset
//   S, Z, V, N      adder sum and flags
//   CFN             00 pass S, 01 CMPEQ, 10 CMPLT, 11 CMPLE
//   RC              destination tag travelling with the operation
//   IN_VALID/READY  upstream handshake
//   OUT_VALID/READY writeback handshake
//   OUT_RESULT/RC   head entry result and tag
//   STICKY_V, CLR_V sticky overflow flag and its synchronous clear
//   dbg_state       buffer occupancy state (00 EMPTY, 01 ONE, 10 TWO)

module beta_cmp_stage #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] S,
  input  logic             Z,
  input  logic             V,
  input  logic             N,
  input  logic [1:0]       CFN,
  input  logic [TAG_W-1:0] RC,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_RESULT,
  output logic [TAG_W-1:0] OUT_RC,
  output logic             STICKY_V,
  input  logic             CLR_V,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_TWO   = 2'b10;

  localparam logic [1:0] CFN_PASS  = 2'b00;
  localparam logic [1:0] CFN_CMPEQ = 2'b01;
  localparam logic [1:0] CFN_CMPLT = 2'b10;
  localparam logic [1:0] CFN_CMPLE = 2'b11;

  logic [1:0]       state;
  logic [WIDTH-1:0] head_result;
  logic [TAG_W-1:0] head_rc;
  logic [WIDTH-1:0] skid_result;
  logic [TAG_W-1:0] skid_rc;
  logic             sticky;

  logic [WIDTH-1:0] new_result;
  logic             accept;
  logic             pop;
  logic             lt;

  assign IN_READY   = (state != ST_TWO);
  assign OUT_VALID  = (state != ST_EMPTY);
  assign OUT_RESULT = head_result;
  assign OUT_RC     = head_rc;
  assign STICKY_V   = sticky;
  assign dbg_state  = state;

  assign accept = IN_VALID & IN_READY;
  assign pop    = OUT_VALID & OUT_READY;

  // Signed less-than from the subtract flags: negative result unless the
  // subtraction overflowed.
  assign lt = N ^ V;

  always_comb begin
    new_result = '0;
    case (CFN)
      CFN_PASS:  new_result = S;
      CFN_CMPEQ: new_result[0] = Z;
      CFN_CMPLT: new_result[0] = lt;
      CFN_CMPLE: new_result[0] = Z | lt;
      default:   new_result = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= ST_EMPTY;
      head_result <= '0;
      head_rc     <= '0;
      skid_result <= '0;
      skid_rc     <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            head_result <= new_result;
            head_rc     <= RC;
            state       <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            // Head leaves and the new entry replaces it in the same edge.
            head_result <= new_result;
            head_rc     <= RC;
          end else if (accept) begin
            skid_result <= new_result;
            skid_rc     <= RC;
            state       <= ST_TWO;
          end else if (pop) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // IN_READY is low here, so only a pop can change anything.
          if (pop) begin
            head_result <= skid_result;
            head_rc     <= skid_rc;
            state       <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  // Set has priority over clear so an overflow in the clearing cycle is
  // not lost. Compares never touch the flag.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sticky <= 1'b0;
    end else if (accept && (CFN == CFN_PASS) && V) begin
      sticky <= 1'b1;
    end else if (CLR_V) begin
      sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_beta_cmp_stage.sv
// Testbench for beta_cmp_stage: directed scenarios plus a random phase.
// Every accepted operation pushes its expected {tag, result} onto a queue;
// every pop observed on the output side is compared against the queue head.

module tb_beta_cmp_stage;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;
  localparam int EW    = WIDTH + TAG_W;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] s;
  logic             z, v, n;
  logic [1:0]       cfn;
  logic [TAG_W-1:0] rc;
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_rc;
  logic             sticky_v;
  logic             clr_v;
  logic [1:0]       dbg_state;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  beta_cmp_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .CLK(clk), .RESET(rst), .S(s), .Z(z), .V(v), .N(n), .CFN(cfn), .RC(rc),
    .IN_VALID(in_valid), .IN_READY(in_ready), .OUT_VALID(out_valid),
    .OUT_READY(out_ready), .OUT_RESULT(out_result), .OUT_RC(out_rc),
    .STICKY_V(sticky_v), .CLR_V(clr_v), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model of result formation
  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] ms, input logic mz,
                                             input logic mv, input logic mn, input logic [1:0] mf);
    logic less;
    less = (mn && !mv) || (!mn && mv);
    if (mf == 2'b00) return ms;
    if (mf == 2'b01) return mz ? 1 : 0;
    if (mf == 2'b10) return less ? 1 : 0;
    return (mz || less) ? 1 : 0;
  endfunction

  // scoreboard: inputs change 1 time unit after posedge, so negedge sees
  // the values that the next posedge will act on.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_without_expected", 64'(out_valid), 64'(1'b0));
        end else begin
          check("sb_entry", 64'({out_rc, out_result}), 64'(exp_q.pop_front()));
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back({rc, model(s, z, v, n, cfn)});
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [WIDTH-1:0] os, input logic oz, input logic ov,
                    input logic on, input logic [1:0] of, input logic [TAG_W-1:0] orc);
    s = os; z = oz; v = ov; n = on; cfn = of; rc = orc; in_valid = 1'b1;
    step();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      in_valid = 1'b0;
      s = $urandom; z = 1'($urandom); v = 1'($urandom); n = 1'($urandom);
      cfn = 2'($urandom); rc = TAG_W'($urandom);
      step();
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (out_valid && budget < 50) begin
      idle(1);
      budget++;
    end
    check("drain_timeout", 64'(out_valid), 64'(1'b0));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_v = 1'b0;
    s = '0; z = 0; v = 0; n = 0; cfn = 0; rc = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_result", 64'(out_result), 64'(0));
    check("rst_out_rc", 64'(out_rc), 64'(0));
    check("rst_sticky", 64'(sticky_v), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    rst = 1'b0;
    idle(1);

    // pass-through
    out_ready = 1'b1;
    op(32'h5, 0, 0, 0, 2'b00, 5'd3);
    check("pass_valid", 64'(out_valid), 64'(1));
    check("pass_result", 64'(out_result), 64'h5);
    check("pass_rc", 64'(out_rc), 64'd3);
    idle(1);
    for (int i = 0; i < 4; i++) begin
      op(32'h100 + i, 0, 0, 0, 2'b00, TAG_W'(i + 8));
      check("stream_in_ready", 64'(in_ready), 64'(1));
      check("stream_result", 64'(out_result), 64'h100 + i);
    end
    idle(1);

    // compares from 7-9 and 9-9
    op(32'hFFFF_FFFE, 0, 0, 1, 2'b10, 5'd1);
    check("cmplt_7_9", 64'(out_result), 64'h1);
    op(32'hFFFF_FFFE, 0, 0, 1, 2'b01, 5'd2);
    check("cmpeq_7_9", 64'(out_result), 64'h0);
    op(32'hFFFF_FFFE, 0, 0, 1, 2'b11, 5'd3);
    check("cmple_7_9", 64'(out_result), 64'h1);
    op(32'h0, 1, 0, 0, 2'b11, 5'd4);
    check("cmple_9_9", 64'(out_result), 64'h1);
    op(32'h0, 1, 0, 0, 2'b10, 5'd5);
    check("cmplt_9_9", 64'(out_result), 64'h0);
    op(32'hFFFF_FFFF, 0, 1, 0, 2'b10, 5'd6);
    check("cmplt_ovf", 64'(out_result), 64'h1);
    idle(1);

    // backpressure
    out_ready = 1'b0;
    op(32'hAAAA_0001, 0, 0, 0, 2'b00, 5'd10);
    check("bp_ready_after_a", 64'(in_ready), 64'(1));
    op(32'hBBBB_0002, 0, 0, 0, 2'b00, 5'd11);
    check("bp_ready_after_b", 64'(in_ready), 64'(0));
    check("bp_state_two", 64'(dbg_state), 64'd2);
    idle(2);
    check("bp_hold_a", 64'(out_result), 64'hAAAA_0001);
    check("bp_hold_rc", 64'(out_rc), 64'd10);
    out_ready = 1'b1;
    idle(1);
    check("bp_second_b", 64'(out_result), 64'hBBBB_0002);
    check("bp_ready_back", 64'(in_ready), 64'(1));
    idle(1);
    check("bp_empty", 64'(out_valid), 64'(0));

    // sticky overflow
    op(32'h8000_0000, 0, 1, 1, 2'b00, 5'd1);
    check("sticky_set", 64'(sticky_v), 64'(1));
    op(32'h3, 0, 0, 0, 2'b00, 5'd2);
    check("sticky_persist", 64'(sticky_v), 64'(1));
    clr_v = 1'b1; idle(1); clr_v = 1'b0;
    check("sticky_clr", 64'(sticky_v), 64'(0));
    clr_v = 1'b1;
    op(32'h8000_0000, 0, 1, 1, 2'b00, 5'd3);
    clr_v = 1'b0;
    check("sticky_set_wins", 64'(sticky_v), 64'(1));
    clr_v = 1'b1; idle(1); clr_v = 1'b0;
    check("sticky_clr2", 64'(sticky_v), 64'(0));
    op(32'h8000_0000, 0, 1, 1, 2'b10, 5'd4);
    check("sticky_cmp_no_set", 64'(sticky_v), 64'(0));
    idle(1);

    // accept + pop in ONE
    op(32'hA, 0, 0, 0, 2'b00, 5'd20);
    op(32'hC, 0, 0, 0, 2'b00, 5'd21);
    check("ap_state_one", 64'(dbg_state), 64'd1);
    check("ap_result_c", 64'(out_result), 64'hC);
    idle(1);
    check("ap_no_dup", 64'(out_valid), 64'(0));

    // random phase
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1)
        op($urandom, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)),
           TAG_W'($urandom));
      else
        idle(1);
    end
    drain();
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    // reset mid-operation with TWO full and sticky set
    out_ready = 1'b0;
    op(32'h7, 0, 1, 0, 2'b00, 5'd1);
    op(32'h8, 0, 0, 0, 2'b00, 5'd2);
    in_valid = 1'b0;
    check("mid_state_two", 64'(dbg_state), 64'd2);
    check("mid_sticky_pre", 64'(sticky_v), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    check("mid_rst_sticky", 64'(sticky_v), 64'(0));
    exp_q.delete();
    rst = 1'b0;
    step();
    check("post_rst_out_valid", 64'(out_valid), 64'(0));
    out_ready = 1'b1;
    op(32'h55, 0, 0, 0, 2'b00, 5'd9);
    check("post_rst_result", 64'(out_result), 64'h55);
    drain();
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/beta_cmp_stage.md
Name: beta_cmp_stage

Overview:
- Execute-stage consumer that sits directly downstream of the adder/subtractor.
- Captures its sum S and flags Z/V/N, then forms the final ALU result. The result is either S passed through (ADD/SUB) or a BETA compare result CMPEQ/CMPLT/CMPLE, packed as a 0/1 word.
- Registers the result with a destination tag behind a 2-entry skid buffer and a valid/ready handshake toward writeback.
- Keeps a sticky overflow flag for the ADD/SUB path.

Parameters:
- WIDTH, 32, datapath width of S and OUT_RESULT.
- TAG_W, 5, width of the destination register tag (RC).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- S  input  WIDTH  sum/difference from the adder/subtractor.
- Z  input  1  adder zero flag.
- V  input  1  adder overflow flag.
- N  input  1  adder negative flag.
- CFN  input  2  function select: 00 pass S, 01 CMPEQ, 10 CMPLT, 11 CMPLE.
- RC  input  TAG_W  destination register tag travelling with the operation.
- IN_VALID  input  1  upstream presents a valid operation this cycle.
- IN_READY  output  1  stage can accept an operation this cycle.
- OUT_VALID  output  1  OUT_RESULT/OUT_RC hold a valid entry.
- OUT_READY  input  1  writeback consumes the head entry this cycle.
- OUT_RESULT  output  WIDTH  final ALU result.
- OUT_RC  output  TAG_W  tag of the head entry.
- STICKY_V  output  1  sticky overflow indicator.
- CLR_V  input  1  synchronous clear of STICKY_V.

Behaviour:
- Reset (async, immediate on RESET=1): state EMPTY; OUT_VALID=0, OUT_RESULT=0, OUT_RC=0, STICKY_V=0, IN_READY=1. Both buffer entries are cleared. Any operation in flight is discarded, with no partial update.
- Result formation (combinational, applied at capture):
  - CFN=00 -> S.
  - CFN=01 -> {0..0, Z}.
  - CFN=10 -> {0..0, N^V}.
  - CFN=11 -> {0..0, Z|(N^V)}.
  - Upper WIDTH-1 bits are zero for compares.
- Accept = IN_VALID & IN_READY. Pop = OUT_VALID & OUT_READY.
- Latency: an operation accepted at edge k appears on OUT_* after edge k (1 cycle). Results emerge strictly in acceptance order.
- Entries: HEAD drives OUT_*; SKID holds the second entry. IN_READY is 1 in EMPTY and ONE, 0 in TWO, and is derived from registered state only (no combinational IN_VALID->IN_READY or OUT_READY->IN_READY path).
- State EMPTY:
  - Accept -> load HEAD, go ONE.
  - Otherwise stay.
- State ONE:
  - Accept & Pop -> HEAD <= new, stay ONE.
  - Accept only -> load SKID, go TWO.
  - Pop only -> go EMPTY.
  - Neither -> hold.
- State TWO:
  - No accept is possible.
  - Pop -> HEAD <= SKID, go ONE.
  - Otherwise hold. OUT_* stays stable while OUT_VALID=1 and OUT_READY=0.
- In EMPTY, OUT_RESULT/OUT_RC hold their last values; only OUT_VALID qualifies them.
- STICKY_V:
  - Set on an accept with CFN=00 and V=1.
  - Cleared by CLR_V=1 at the edge.
  - Simultaneous set and CLR_V: set wins, so STICKY_V=1.
  - Compares never set it, even if V=1.
- IN_VALID=0 with garbage S/flags/RC: ignored entirely.

Test Plan:
- Reset mid-operation: fill TWO, assert RESET for a partial cycle -> OUT_VALID=0 and IN_READY=1 immediately; STICKY_V=0.
- Pass-through with OUT_READY=1: S=0x0000_0005, CFN=00, RC=3 -> next cycle OUT_VALID=1, OUT_RESULT=0x0000_0005, OUT_RC=3. Streaming 4 back-to-back ops yields 4 results in order, and IN_READY stays 1.
- Compares, using S/flags from 7-9 (S=0xFFFF_FFFE, N=1, V=0, Z=0):
  - CMPLT -> 0x1
  - CMPEQ -> 0x0
  - CMPLE -> 0x1
  - From 9-9 (Z=1): CMPLE -> 0x1, CMPLT -> 0x0.
- Backpressure: OUT_READY=0, accept ops A then B -> IN_READY=0 after B and OUT_RESULT holds A. Raise OUT_READY -> A, then B on consecutive cycles, and IN_READY returns to 1 after the first pop.
- Sticky overflow:
  - ADD 0x7FFF_FFFF+1 (V=1, CFN=00) -> STICKY_V=1, which persists across later clean ops.
  - CLR_V alone -> 0.
  - CLR_V concurrent with another V=1 accept -> remains 1.
  - CMPLT with V=1 -> no set.
- Accept+pop in ONE: HEAD=A, OUT_READY=1, IN_VALID=1 with C -> state stays ONE and OUT_RESULT becomes C the next cycle, with no bubble and no duplicate.
